// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog timer: FSM state encoding,
// counter/pulse defaults and the reload-register reset pattern.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } wdt_state_t;

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_RUN    = 2'(RUN);
  localparam logic [1:0] S_EXPIRE = 2'(EXPIRE);

  localparam int WDT_CNT_W     = 16;
  localparam int WDT_RST_PULSE = 4;

  // Reload register and counter reset to all ones of this bit.
  localparam logic WDT_RELOAD_RST_BIT = 1'b1;

  // Last pulse-counter value before EXPIRE ends (pulse counter is 4 bits).
  function automatic logic [3:0] pulse_last(input int pulse);
    return 4'(pulse - 1);
  endfunction

endpackage

// File: rtl/wdt_tick_detect.sv
// Rising-edge detector for the divided watch clock, treated as data on clk.
// Produces a registered one-cycle tick one clk after watch_clk is seen 0 then 1.
module wdt_tick_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic watch_clk,
  output logic tick
);

  logic r_wc_prev;
  logic r_tick;

  // Sample history of watch_clk and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wc_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_wc_prev <= watch_clk;
      r_tick    <= watch_clk & ~r_wc_prev;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/watchdog_timer.sv
// Watchdog timer: countdown on watch_clk ticks, kick refresh, reset-request pulse.
// Optional early-warning interrupt enabled by defining WDT_EARLY_WARN_EN.
module watchdog_timer
  import wdt_pkg::*;
#(
  parameter int CNT_W     = WDT_CNT_W,
  parameter int RST_PULSE = WDT_RST_PULSE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             watch_clk,
  input  logic             kick,
  input  logic [CNT_W-1:0] load_val,
  input  logic             load_we,
`ifdef WDT_EARLY_WARN_EN
  input  logic [CNT_W-1:0] warn_thresh,
  output logic             early_irq,
`endif
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state,
  output logic             wdt_rst_req,
  output logic             expired
);

  localparam logic [CNT_W-1:0] RELOAD_RST = {CNT_W{WDT_RELOAD_RST_BIT}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       PULSE_LAST = pulse_last(RST_PULSE);

  logic             w_tick;
  logic [1:0]       r_state;
  logic [1:0]       w_state_dec;
  logic [1:0]       w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] w_reload_nx;
  logic [3:0]       r_pulse;
  logic [3:0]       w_pulse_nx;
  logic             r_rst_req;
  logic             w_rst_req_nx;
  logic             r_expired;
  logic             w_expired_nx;

  wdt_tick_detect u_tick_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .watch_clk (watch_clk),
    .tick      (w_tick)
  );

  // Reload register write; zero is promoted to one so a reload never starts at zero.
  always_comb begin
    w_reload_nx = r_reload;
    if (load_we) begin
      if (load_val == CNT_ZERO) begin
        w_reload_nx = CNT_ONE;
      end else begin
        w_reload_nx = load_val;
      end
    end else begin
      w_reload_nx = r_reload;
    end
  end

  // Unreachable encoding 3 behaves as IDLE.
  always_comb begin
    if ((r_state == S_RUN) || (r_state == S_EXPIRE)) begin
      w_state_dec = r_state;
    end else begin
      w_state_dec = S_IDLE;
    end
  end

  // FSM next-state, counter, pulse and flag logic; reloads use the pre-write register.
  always_comb begin
    w_state_nx   = w_state_dec;
    w_cnt_nx     = r_cnt;
    w_pulse_nx   = r_pulse;
    w_rst_req_nx = 1'b0;
    w_expired_nx = r_expired;
    case (w_state_dec)
      S_RUN: begin
        if (kick) begin
          w_expired_nx = 1'b0;
        end else begin
          w_expired_nx = r_expired;
        end
        if (!en) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = r_reload;
        end else if (kick) begin
          w_cnt_nx = r_reload;
        end else if (w_tick) begin
          if (r_cnt == CNT_ZERO) begin
            w_state_nx   = S_EXPIRE;
            w_expired_nx = 1'b1;
            w_rst_req_nx = 1'b1;
            w_pulse_nx   = 4'd0;
          end else begin
            w_cnt_nx = r_cnt - CNT_ONE;
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      S_EXPIRE: begin
        // en is only looked at once the pulse has run its full length.
        if (r_pulse == PULSE_LAST) begin
          w_cnt_nx     = r_reload;
          w_pulse_nx   = 4'd0;
          w_rst_req_nx = 1'b0;
          if (en) begin
            w_state_nx = S_RUN;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_pulse_nx   = r_pulse + 4'd1;
          w_rst_req_nx = 1'b1;
        end
      end
      default: begin
        w_cnt_nx = r_reload;
        if (kick) begin
          w_expired_nx = 1'b0;
        end else begin
          w_expired_nx = r_expired;
        end
        if (en) begin
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
    endcase
  end

  // State, counter, reload register and output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= RELOAD_RST;
      r_reload  <= RELOAD_RST;
      r_pulse   <= 4'd0;
      r_rst_req <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_reload  <= w_reload_nx;
      r_pulse   <= w_pulse_nx;
      r_rst_req <= w_rst_req_nx;
      r_expired <= w_expired_nx;
    end
  end

`ifdef WDT_EARLY_WARN_EN
  logic r_early_irq;

  // Early warning tracks the next RUN count against the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_early_irq <= 1'b0;
    end else begin
      r_early_irq <= (w_state_nx == S_RUN) && (w_cnt_nx <= warn_thresh);
    end
  end

  assign early_irq = r_early_irq;
`endif

  assign cnt         = r_cnt;
  assign state       = r_state;
  assign wdt_rst_req = r_rst_req;
  assign expired     = r_expired;

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: directed scenarios plus randomized
// stimulus against a behavioural model; honours WDT_EARLY_WARN_EN.
module tb_watchdog_timer;

  localparam int CNT_W     = 16;
  localparam int RST_PULSE = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              watch_clk = 1'b0;
  logic              kick = 1'b0;
  logic [CNT_W-1:0]  load_val = 16'd0;
  logic              load_we = 1'b0;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        state;
  logic              wdt_rst_req;
  logic              expired;
`ifdef WDT_EARLY_WARN_EN
  logic [CNT_W-1:0]  warn_thresh = 16'd2;
  logic              early_irq;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 counting, 2 reset pulse in progress
  int         m_mode = 0;
  logic [15:0] m_cnt = 16'hFFFF;
  logic [15:0] m_reload = 16'hFFFF;
  int         m_pulse_left = 0;
  bit         m_exp = 1'b0;
  bit         m_prev = 1'b0;
  bit         m_tick = 1'b0;
  bit         m_early = 1'b0;

  watchdog_timer #(.CNT_W(CNT_W), .RST_PULSE(RST_PULSE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .watch_clk   (watch_clk),
    .kick        (kick),
    .load_val    (load_val),
    .load_we     (load_we),
`ifdef WDT_EARLY_WARN_EN
    .warn_thresh (warn_thresh),
    .early_irq   (early_irq),
`endif
    .cnt         (cnt),
    .state       (state),
    .wdt_rst_req (wdt_rst_req),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 16'hFFFF; m_reload = 16'hFFFF; m_pulse_left = 0;
    m_exp = 1'b0; m_prev = 1'b0; m_tick = 1'b0; m_early = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] old_reload;
    bit t;
    old_reload = m_reload;
    t = m_tick;
    m_tick = watch_clk && !m_prev;
    m_prev = watch_clk;
    if (load_we) m_reload = (load_val == 16'd0) ? 16'd1 : load_val;
    if (m_mode == 2) begin
      m_pulse_left = m_pulse_left - 1;
      if (m_pulse_left == 0) begin
        m_mode = en ? 1 : 0;
        m_cnt = old_reload;
      end
    end else begin
      if (kick) m_exp = 1'b0;
      if (m_mode == 0) begin
        m_cnt = old_reload;
        if (en) m_mode = 1;
      end else if (!en) begin
        m_mode = 0;
        m_cnt = old_reload;
      end else if (kick) begin
        m_cnt = old_reload;
      end else if (t) begin
        if (m_cnt == 16'd0) begin
          m_mode = 2;
          m_exp = 1'b1;
          m_pulse_left = RST_PULSE;
        end else begin
          m_cnt = m_cnt - 16'd1;
        end
      end
    end
`ifdef WDT_EARLY_WARN_EN
    m_early = (m_mode == 1) && (m_cnt <= warn_thresh);
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("wdt_rst_req", 32'(wdt_rst_req), 32'(m_mode == 2));
      chk("expired", 32'(expired), 32'(m_exp));
`ifdef WDT_EARLY_WARN_EN
      chk("early_irq", 32'(early_irq), 32'(m_early));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wc_pulse();
    watch_clk = 1'b1; step(1);
    watch_clk = 1'b0; step(1);
  endtask

  // Counts reset-request cycles starting from an already-observed high cycle.
  task automatic count_pulse(input int drop_en_at, output int n);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (wdt_rst_req) begin
        n++;
        if (n == drop_en_at) en = 1'b0;
      end else begin
        break;
      end
    end
  endtask

  initial begin
    int n;
    step(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'hFFFF);
    chk("rst_req_low", 32'(wdt_rst_req), 32'd0);

    // Reload 3, count 3,2,1,0 then time out
    load_val = 16'd3; load_we = 1'b1; step(1);
    load_we = 1'b0; en = 1'b1; step(1);
    chk("run_cnt3", 32'(cnt), 32'd3);
    wc_pulse(); chk("cnt2", 32'(cnt), 32'd2);
    wc_pulse(); chk("cnt1", 32'(cnt), 32'd1);
    wc_pulse(); chk("cnt0", 32'(cnt), 32'd0);
    wc_pulse();
    chk("exp_state", 32'(state), 32'd2);
    chk("exp_flag", 32'(expired), 32'd1);
    count_pulse(0, n);
    chk("pulse_len", 32'(n), 32'd4);
    chk("after_exp_state", 32'(state), 32'd1);
    chk("after_exp_cnt", 32'(cnt), 32'd3);

    // Kick coincident with tick at cnt=1
    wc_pulse(); wc_pulse();
    chk("pre_kick_cnt", 32'(cnt), 32'd1);
    watch_clk = 1'b1; step(1);
    watch_clk = 1'b0; kick = 1'b1; step(1);
    kick = 1'b0;
    chk("kick_cnt", 32'(cnt), 32'd3);
    chk("kick_clr_exp", 32'(expired), 32'd0);

    // Writing zero stores one; cnt untouched until reload
    load_val = 16'd0; load_we = 1'b1; step(1);
    load_we = 1'b0;
    chk("we_no_reload", 32'(cnt), 32'd3);
    kick = 1'b1; step(1); kick = 1'b0;
    chk("reload_one", 32'(cnt), 32'd1);

    // en dropped in pulse cycle 2: full pulse, then IDLE
    wc_pulse(); wc_pulse();
    chk("exp2_state", 32'(state), 32'd2);
    count_pulse(2, n);
    chk("pulse_len_en0", 32'(n), 32'd4);
    chk("idle_after", 32'(state), 32'd0);
    chk("idle_cnt", 32'(cnt), 32'd1);

    // Asynchronous reset mid-pulse
    en = 1'b1; step(1);
    wc_pulse(); wc_pulse();
    chk("exp3_state", 32'(state), 32'd2);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(wdt_rst_req), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_cnt", 32'(cnt), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en = ($urandom_range(15, 0) != 0);
      kick = ($urandom_range(39, 0) == 0);
      load_we = ($urandom_range(24, 0) == 0);
      load_val = 16'($urandom_range(12, 0));
      if ($urandom_range(2, 0) == 0) watch_clk = ~watch_clk;
    end
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
